// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the integer register file: widths, the XZR index
// and the packed read-mux input array type.
package cpu_pkg;

  localparam int DATA_W   = 64;
  localparam int NUM_REGS = 32;
  localparam int SEL_W    = 5;

  localparam logic [SEL_W-1:0] XZR_IDX = 5'd31;

  // One DATA_W lane per register index; entry XZR_IDX is always driven with zero.
  typedef logic [NUM_REGS-1:0][DATA_W-1:0] rf_mux_in_t;

  function automatic logic is_xzr(input logic [SEL_W-1:0] idx);
    return idx == XZR_IDX;
  endfunction

endpackage

// File: rtl/regfile_32x64_mux.sv
// Vectored 32:1 multiplexer: every output bit selects the same-position bit
// of the register addressed by sel.
module regfile_32x64_mux
  import cpu_pkg::*;
(
  input  rf_mux_in_t        din,
  input  logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] dout
);

  genvar gi, gj;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_lane
      logic [NUM_REGS-1:0] column;
      for (gj = 0; gj < NUM_REGS; gj++) begin : g_src
        assign column[gj] = din[gj][gi];
      end
      assign dout[gi] = column[sel];
    end
  endgenerate

endmodule

// File: rtl/regfile_32x64.sv
// 31 x 64-bit register file with hardwired-zero XZR, one write port and two
// combinational read ports. Define REGFILE_BYPASS_EN for write-through forwarding.
module regfile_32x64
  import cpu_pkg::*;
#(
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int NUM_REGS = cpu_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegWrite,
  input  logic [SEL_W-1:0]  WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [SEL_W-1:0]  ReadRegister1,
  input  logic [SEL_W-1:0]  ReadRegister2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);

  logic [NUM_REGS-1:0] wr_dec;
  rf_mux_in_t          mux_in;
  logic [DATA_W-1:0]   rd1_arr;
  logic [DATA_W-1:0]   rd2_arr;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_dec
      assign wr_dec[gi] = RegWrite && (WriteRegister == SEL_W'(gi));
    end

    // X0..X30 have storage; the decoder output for XZR is intentionally left unused.
    for (gi = 0; gi < NUM_REGS - 1; gi++) begin : g_reg
      logic [DATA_W-1:0] x_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          x_reg <= '0;
        end else if (wr_dec[gi]) begin
          x_reg <= WriteData;
        end
      end
      assign mux_in[gi] = x_reg;
    end
  endgenerate

  assign mux_in[NUM_REGS-1] = '0;

  regfile_32x64_mux u_rd1_mux (
    .din  (mux_in),
    .sel  (ReadRegister1),
    .dout (rd1_arr)
  );

  regfile_32x64_mux u_rd2_mux (
    .din  (mux_in),
    .sel  (ReadRegister2),
    .dout (rd2_arr)
  );

`ifdef REGFILE_BYPASS_EN
  // Forwarding is suppressed while in reset so every index reads zero then.
  logic wr_live;
  assign wr_live   = rst_n && RegWrite && !is_xzr(WriteRegister);
  assign ReadData1 = (wr_live && (ReadRegister1 == WriteRegister)) ? WriteData : rd1_arr;
  assign ReadData2 = (wr_live && (ReadRegister2 == WriteRegister)) ? WriteData : rd2_arr;
`else
  assign ReadData1 = rd1_arr;
  assign ReadData2 = rd2_arr;
`endif

  a_regwrite_known: assert property (@(posedge clk) disable iff (!rst_n)
    !$isunknown(RegWrite));
  a_dec_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    RegWrite |-> $onehot(wr_dec));
  a_dec_idle: assert property (@(posedge clk) disable iff (!rst_n)
    !RegWrite |-> (wr_dec == '0));

endmodule

// File: tb/tb_regfile_32x64.sv
// Self-checking bench for regfile_32x64: directed scenarios plus random traffic
// checked against an array model of the architectural registers.
module tb_regfile_32x64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [63:0] ReadData1;
  logic [63:0] ReadData2;

  int errors = 0;
  int checks = 0;
  logic [63:0] model [32];

  regfile_32x64 dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] expect_rd(input logic [4:0] idx);
    logic [63:0] v;
    v = (idx == 5'd31 || !rst_n) ? 64'd0 : model[idx];
`ifdef REGFILE_BYPASS_EN
    if (rst_n && RegWrite && WriteRegister != 5'd31 && WriteRegister == idx) v = WriteData;
`endif
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic read_both(input string tag, input logic [4:0] a, input logic [4:0] b);
    ReadRegister1 = a;
    ReadRegister2 = b;
    #1;
    check($sformatf("%s rd1[%0d]", tag, a), ReadData1, expect_rd(a));
    check($sformatf("%s rd2[%0d]", tag, b), ReadData2, expect_rd(b));
  endtask

  task automatic wr(input logic we, input logic [4:0] idx, input logic [63:0] d);
    @(negedge clk);
    RegWrite = we; WriteRegister = idx; WriteData = d;
    @(posedge clk);
    if (rst_n && we && idx != 5'd31) model[idx] = d;
    #1;
    RegWrite = 1'b0;
  endtask

  initial begin
    logic [63:0] pat;
    logic        we;
    logic [4:0]  idx;
    logic [63:0] d;

    rst_n = 1'b0; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
    ReadRegister1 = '0; ReadRegister2 = '0;
    for (int i = 0; i < 32; i++) model[i] = '0;

    #12;
    read_both("reset", 5'd0, 5'd30);
    read_both("reset", 5'd31, 5'd5);
    @(negedge clk) rst_n = 1'b1;

    // Fill every writable register with a recognisable pattern.
    for (int i = 0; i < 31; i++) wr(1'b1, 5'(i), 64'h1111_0000_0000_0000 + 64'(i));
    for (int i = 0; i < 32; i++) begin
      read_both("fill", 5'(i), 5'(31 - i));
      pat = (i == 31) ? 64'd0 : 64'h1111_0000_0000_0000 + 64'(i);
      check($sformatf("fill_const[%0d]", i), ReadData1, pat);
    end

    wr(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
    read_both("xzr", 5'd31, 5'd31);
    check("xzr_const", ReadData1, 64'd0);
    for (int i = 0; i < 31; i++) read_both("xzr_keep", 5'(i), 5'(i));

    // Same-edge write/read hazard on X7.
    wr(1'b1, 5'd7, 64'h1);
    @(negedge clk);
    RegWrite = 1'b1; WriteRegister = 5'd7; WriteData = 64'hABCD;
    ReadRegister1 = 5'd7; ReadRegister2 = 5'd31;
    #1;
`ifdef REGFILE_BYPASS_EN
    pat = 64'hABCD;
`else
    pat = 64'h1;
`endif
    check("haz_pre", ReadData1, pat);
    check("haz_pre_xzr", ReadData2, 64'd0);
    @(posedge clk);
    model[7] = 64'hABCD;
    #1;
    RegWrite = 1'b0;
    check("haz_post", ReadData1, 64'hABCD);

    for (int i = 0; i < 10; i++) wr(1'b0, 5'd3, 64'h55);
    read_both("we0", 5'd3, 5'd3);
    check("we0_const", ReadData1, 64'h1111_0000_0000_0003);

    // Random traffic with reads checked both before and after each edge.
    for (int n = 0; n < 200; n++) begin
      we  = 1'($urandom_range(0, 1));
      idx = 5'($urandom);
      d   = {$urandom, $urandom};
      @(negedge clk);
      RegWrite = we; WriteRegister = idx; WriteData = d;
      read_both("rnd_pre", idx, 5'($urandom));
      @(posedge clk);
      if (we && idx != 5'd31) model[idx] = d;
      #1;
      RegWrite = 1'b0;
      read_both("rnd_post", idx, 5'($urandom));
    end

    // Asynchronous reset asserted mid-cycle.
    wr(1'b1, 5'd5, 64'hDEAD);
    read_both("pre_rst", 5'd5, 5'd5);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    #1;
    read_both("async_rst", 5'd5, 5'd5);
    check("async_rst_const", ReadData1, 64'd0);

    @(negedge clk);
    RegWrite = 1'b1; WriteRegister = 5'd2; WriteData = 64'h99;
    read_both("rst_wr_pre", 5'd2, 5'd2);
    @(posedge clk);
    #1;
    read_both("rst_wr_edge", 5'd2, 5'd2);
    @(negedge clk);
    RegWrite = 1'b0;
    rst_n = 1'b1;
    #1;
    read_both("rst_rel", 5'd2, 5'd30);
    check("rst_rel_const", ReadData1, 64'd0);

    wr(1'b1, 5'd2, 64'h99);
    read_both("first_wr", 5'd2, 5'd31);
    check("first_wr_const", ReadData1, 64'h99);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_32x64.md
REGFILE_32X64 -- requirements
Module: regfile_32x64

Interface
REQ-001 Parameter: DATA_W, 64, width of each register and of every data port.
REQ-002 Parameter: NUM_REGS, 32, register count; fixed at 32 to match the 5-bit selects.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: RegWrite  input  1  write enable for the write port.
REQ-006 Port: WriteRegister  input  5  destination register index.
REQ-007 Port: WriteData  input  DATA_W  data to write.
REQ-008 Port: ReadRegister1  input  5  read port 1 index.
REQ-009 Port: ReadRegister2  input  5  read port 2 index.
REQ-010 Port: ReadData1  output  DATA_W  read port 1 data, combinational.
REQ-011 Port: ReadData2  output  DATA_W  read port 2 data, combinational.

Function
REQ-012 Storage: 31 writable DATA_W registers X0..X30; X31 is XZR, has no storage and always reads 0.
REQ-013 Write decode: 5-to-32 one-hot decoder gated by RegWrite; exactly one register enable asserted when RegWrite=1, none when RegWrite=0.
REQ-014 Write timing: on the rising clk edge with RegWrite=1 and WriteRegister!=31, X[WriteRegister] <= WriteData; other registers hold.
REQ-015 Write to X31: silently discarded; no state change, no error flag.
REQ-016 Read path: each port is a vectored 32:1 mux of DATA_W lanes selected by its ReadRegisterN, input 31 tied to 0.
REQ-017 Read latency: zero cycles; ReadDataN follows ReadRegisterN and the stored contents combinationally.
REQ-018 Both read ports are independent; identical indices on both ports return identical data.
REQ-019 Read of a register written on the same edge: without bypass, the pre-edge value until the edge, the new value after it.
REQ-020 RegWrite X or Z: treated as no write in simulation; assertion fires.

Reset
REQ-021 rst_n low asynchronously clears X0..X30 to 0 regardless of clk; ReadData1/2 read 0 for all indices while rst_n is low.
REQ-022 rst_n low during an edge with RegWrite=1: the reset wins and the write is lost.
REQ-023 Release of rst_n is synchronised externally; the first write is accepted on the first rising edge with rst_n high.

Configuration
REQ-024 Macro REGFILE_BYPASS_EN: when defined, if RegWrite=1, WriteRegister!=31 and ReadRegisterN==WriteRegister, ReadDataN = WriteData combinationally (write-through forwarding for the writeback-to-decode hazard).
REQ-025 Without REGFILE_BYPASS_EN: no forwarding path; behaviour per REQ-019; the pipeline resolves the hazard by stalling.
REQ-026 Bypass never applies to index 31; XZR reads 0 in both builds.

Structure
REQ-027 Shared package cpu_pkg holds DATA_W, NUM_REGS, the XZR index constant (5'd31) and the typedef for the 32 x DATA_W read-mux input array.
REQ-028 One sub-module: the existing vectored 32:1 mux (64 lanes), instantiated once per read port; decoder and storage are inline.

Verification
REQ-029 Reset: rst_n=0 mid-cycle with X5=0xDEAD -> X5 reads 0 immediately, without a clk edge.
REQ-030 Write/read all: write X_i = 0x1111_0000_0000_0000 + i for i=0..30, then read every index on both ports -> exact values, X31=0.
REQ-031 XZR: write 0xFFFF_FFFF_FFFF_FFFF to index 31 -> ReadData1 at index 31 = 0; X0..X30 unchanged.
REQ-032 Same-cycle hazard: RegWrite=1, WriteRegister=7, WriteData=0xABCD, ReadRegister1=7, old X7=0x1 -> pre-edge 0xABCD with REGFILE_BYPASS_EN, 0x1 without; 0xABCD after the edge in both builds.
REQ-033 Write disabled: RegWrite=0, WriteRegister=3, WriteData=0x55 over 10 edges -> X3 keeps its prior value.
REQ-034 Reset vs write: rst_n=0 on an edge with RegWrite=1, WriteRegister=2, WriteData=0x99 -> X2 = 0 after reset release.
